// File: rtl/wb_bus_if.sv
// Classic single-beat 8-bit Wishbone link between one master and one slave.
// The master modport drives the request side; the slave modport drives terminations and read data.
interface wb_bus_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [7:0]            wdat;
  logic [7:0]            rdat;
  logic                  ack;
  logic                  err;
  logic                  rty;

  modport master (
    output cyc, stb, we, adr, wdat,
    input  rdat, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, wdat,
    output rdat, ack, err, rty
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter; the grant is held for the whole cyc.
// Optional stall watchdog with ABORT state is enabled by defining WB_ARBITER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no grant; arbitrate among masters asserting cyc
// GRANT0 | host bridge (m0) owns the slave port
// GRANT1 | search engine (m1) owns the slave port
// ABORT  | watchdog fired; slave held off until the owner drops cyc
module wb_bus_arbiter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  wb_bus_if.slave    m0,
  wb_bus_if.slave    m1,
  wb_bus_if.master   s,
  output logic [1:0] gnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
`ifdef WB_ARBITER_TIMEOUT_EN
    ,
    ABORT  = 2'd3
`endif
  } state_t;

  state_t state;
  logic   last_grant;
  logic   granted;
  logic   own_cyc;
  logic   own_stb;
  logic   timeout_hit;

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_CYCLES);
  logic [15:0] stall_cnt;
`endif

  // last_grant is set on grant entry, so it also names the owner in GRANTx and ABORT.
  assign granted = (state == GRANT0) || (state == GRANT1);
  assign own_cyc = last_grant ? m1.cyc : m0.cyc;
  assign own_stb = last_grant ? m1.stb : m0.stb;

`ifdef WB_ARBITER_TIMEOUT_EN
  assign timeout_hit = granted && own_cyc && (stall_cnt == TIMEOUT_CNT);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      gnt_o      <= 2'b00;
      last_grant <= 1'b1;
`ifdef WB_ARBITER_TIMEOUT_EN
      stall_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0.cyc && (!m1.cyc || last_grant)) begin
            state      <= GRANT0;
            gnt_o      <= 2'b01;
            last_grant <= 1'b0;
`ifdef WB_ARBITER_TIMEOUT_EN
            stall_cnt  <= '0;
`endif
          end else if (m1.cyc) begin
            state      <= GRANT1;
            gnt_o      <= 2'b10;
            last_grant <= 1'b1;
`ifdef WB_ARBITER_TIMEOUT_EN
            stall_cnt  <= '0;
`endif
          end
        end
        GRANT0, GRANT1: begin
          if (!own_cyc) begin
            state <= IDLE;
            gnt_o <= 2'b00;
          end
`ifdef WB_ARBITER_TIMEOUT_EN
          else if (timeout_hit) begin
            state <= ABORT;
            gnt_o <= 2'b00;
          end else if (s.ack || s.err || s.rty) begin
            stall_cnt <= '0;
          end else if (own_stb) begin
            stall_cnt <= stall_cnt + 16'd1;
          end
`endif
        end
`ifdef WB_ARBITER_TIMEOUT_EN
        ABORT: begin
          if (!own_cyc) state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
          gnt_o <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.adr   = '0;
    s.wdat  = 8'h00;
    m0.ack  = 1'b0;
    m0.err  = 1'b0;
    m0.rty  = 1'b0;
    m1.ack  = 1'b0;
    m1.err  = 1'b0;
    m1.rty  = 1'b0;
    m0.rdat = s.rdat;
    m1.rdat = s.rdat;
    if (granted) begin
      s.cyc  = own_cyc && !timeout_hit;
      s.stb  = own_stb && !timeout_hit;
      s.we   = last_grant ? m1.we   : m0.we;
      s.adr  = last_grant ? m1.adr  : m0.adr;
      s.wdat = last_grant ? m1.wdat : m0.wdat;
      if (last_grant) begin
        m1.ack = s.ack;
        m1.err = s.err || timeout_hit;
        m1.rty = s.rty;
      end else begin
        m0.ack = s.ack;
        m0.err = s.err || timeout_hit;
        m0.rty = s.rty;
      end
    end
  end

endmodule
